// File: rtl/adder8_rr_arbiter.sv
// rtl/adder8_rr_arbiter.sv - round-robin arbiter sharing one registered 8-bit adder
// Grants one requester at a time, waits out the adder latency, returns a tagged response.
module adder8_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 1,
  parameter int CNTW    = 16,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        add_a,
  output logic [7:0]        add_b,
  input  logic [7:0]        add_out,
  input  logic              add_p,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_sum,
  output logic              rsp_carry,
  output logic              busy,
  output logic [CNTW-1:0]   op_count
);

  localparam int WCW = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] idx;
  logic           grant_found;
  logic [WCW-1:0] wait_cnt;

  // Scan starts one past the last winner, so the previous winner is checked last.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign req_ready = (state == IDLE && grant_found) ? (NREQ'(1) << grant_id) : '0;

  // Operands are held from grant to acceptance, so the adder output is stable in RESP.
  assign rsp_sum   = add_out;
  assign rsp_carry = add_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= IDW'(NREQ - 1);
      add_a     <= '0;
      add_b     <= '0;
      rsp_id    <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            add_a    <= req_a[{grant_id, 3'b000} +: 8];
            add_b    <= req_b[{grant_id, 3'b000} +: 8];
            rsp_id   <= grant_id;
            rr_ptr   <= grant_id;
            wait_cnt <= WCW'(ADD_LAT);
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == WCW'(1)) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
            if (op_count != '1) op_count <= op_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder8_rr_arbiter.sv
// tb/tb_adder8_rr_arbiter.sv - self-checking bench for adder8_rr_arbiter
// Vector table plus directed multi-cycle sequences; a scoreboard checks every response.
module tb_adder8_rr_arbiter;

  localparam int NREQ    = 4;
  localparam int ADD_LAT = 1;
  localparam int CNTW    = 4;
  localparam int IDW     = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        add_a, add_b, add_out;
  logic              add_p;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_sum;
  logic              rsp_carry;
  logic              busy;
  logic [CNTW-1:0]   op_count;

  always #5 clk = ~clk;

  adder8_rr_arbiter #(.NREQ(NREQ), .ADD_LAT(ADD_LAT), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_out(add_out), .add_p(add_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_carry(rsp_carry), .busy(busy), .op_count(op_count)
  );

  // Registered adder stand-in with the same reset as the arbiter
  logic [8:0] pipe [ADD_LAT];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ADD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
      for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign add_out = pipe[ADD_LAT-1][7:0];
  assign add_p   = pipe[ADD_LAT-1][8];

  int errors = 0;
  int checks = 0;
  int n_rsp  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  typedef struct { int id; logic [8:0] res; } sb_t;
  sb_t sb[$];

  always @(negedge clk) begin
    sb_t e;
    int  gid;
    if (reset) begin
      sb.delete();
    end else begin
      if (|req_ready) begin
        gid = onehot_idx(req_ready);
        check("grant_onehot", $countones(req_ready), 1);
        check("grant_unrequested", int'(req_ready & ~req_valid), 0);
        e.id  = gid;
        e.res = {1'b0, req_a[gid*8 +: 8]} + {1'b0, req_b[gid*8 +: 8]};
        sb.push_back(e);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sb_id", int'(rsp_id), e.id);
          check("sb_sum", int'(rsp_sum), int'(e.res[7:0]));
          check("sb_carry", int'(rsp_carry), int'(e.res[8]));
        end
        n_rsp++;
      end
    end
  end

  typedef struct { int id; logic [7:0] a; logic [7:0] b; logic [7:0] sum; logic carry; } vec_t;
  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(output int gid);
    int cyc = 0;
    gid = -1;
    while (cyc < 30) begin
      @(negedge clk);
      if (|req_ready) begin
        gid = onehot_idx(req_ready);
        break;
      end
      tick();
      cyc++;
    end
    if (gid < 0) check("grant_timeout", 0, 1);
  endtask

  task automatic drain();
    int cyc = 0;
    while ((sb.size() != 0 || busy) && cyc < 50) begin
      tick();
      cyc++;
    end
    check("drain_timeout", (cyc < 50) ? 1 : 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    req_valid = '0;
    req_valid[v.id] = 1'b1;
    req_a[v.id*8 +: 8] = v.a;
    req_b[v.id*8 +: 8] = v.b;
    @(negedge clk);
    check("vec_grant", int'(req_ready), 1 << v.id);
    tick();
    req_valid = '0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
      @(negedge clk);
    end
    check("vec_latency", lat, ADD_LAT + 1);
    check("vec_id", int'(rsp_id), v.id);
    check("vec_sum", int'(rsp_sum), int'(v.sum));
    check("vec_carry", int'(rsp_carry), int'(v.carry));
    tick();
  endtask

  initial begin
    int   gid, last, cyc, ng, target;
    vec_t v;
    logic [8:0] r;

    vecs[0] = '{0, 8'h12, 8'h34, 8'h46, 1'b0};
    vecs[1] = '{2, 8'hF0, 8'h20, 8'h10, 1'b1};
    vecs[2] = '{2, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[3] = '{1, 8'h80, 8'h80, 8'h00, 1'b1};
    vecs[4] = '{3, 8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[5] = '{0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[6] = '{3, 8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[7] = '{1, 8'hFF, 8'hFF, 8'hFE, 1'b1};

    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_op_count", int'(op_count), 0);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_add_a", int'(add_a), 0);
    check("rst_add_b", int'(add_b), 0);
    check("rst_rsp_id", int'(rsp_id), 0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      if (i == 0) check("op_count_first", int'(op_count), 1);
    end
    check("op_count_table", int'(op_count), 8);

    // All requesters held valid: rotation from reset, ADD_LAT+2 cycles apart
    do_reset();
    req_a = 32'h11223344;
    req_b = 32'hF0E0D0C0;
    req_valid = '1;
    cyc = 0; ng = 0; last = 0;
    while (ng < 6 && cyc < 60) begin
      @(negedge clk);
      if (|req_ready) begin
        check("rr_order", onehot_idx(req_ready), ng % NREQ);
        if (ng > 0) check("rr_spacing", cyc - last, ADD_LAT + 2);
        last = cyc;
        ng++;
      end
      tick();
      cyc++;
    end
    check("rr_grants", ng, 6);
    req_valid = '0;
    drain();

    // Backpressure: response held steady, no grants while stalled
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_a[15:8] = 8'h33;
    req_b[15:8] = 8'h44;
    wait_grant(gid);
    check("bp_grant", gid, 1);
    tick();
    req_valid = 4'b0001;
    cyc = 0;
    @(negedge clk);
    while (!rsp_valid && cyc < 10) begin
      tick();
      cyc++;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", int'(rsp_valid), 1);
      check("bp_id", int'(rsp_id), 1);
      check("bp_sum", int'(rsp_sum), 8'h77);
      check("bp_req_ready", int'(req_ready), 0);
      tick();
      @(negedge clk);
    end
    tick();
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("bp_accept_valid", int'(rsp_valid), 1);
    tick();
    @(negedge clk);
    check("bp_release", int'(rsp_valid), 0);
    check("bp_busy", int'(busy), 0);
    drain();

    // Reset one cycle after a grant drops the in-flight op
    req_valid = 4'b0001;
    req_a[7:0] = 8'h05;
    req_b[7:0] = 8'h06;
    wait_grant(gid);
    tick();
    req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_wait_no_rsp", int'(rsp_valid), 0);
      tick();
    end
    check("rst_wait_op_count", int'(op_count), 0);
    check("rst_wait_busy", int'(busy), 0);
    req_valid = 4'b1010;
    wait_grant(gid);
    check("rst_wait_first", gid, 1);
    tick();
    wait_grant(gid);
    check("rst_wait_second", gid, 3);
    tick();
    req_valid = '0;
    drain();

    // Saturating counter
    do_reset();
    for (int n = 1; n <= 17; n++) begin
      v.id = n % NREQ;
      v.a  = 8'($urandom_range(0, 255));
      v.b  = 8'($urandom_range(0, 255));
      r    = {1'b0, v.a} + {1'b0, v.b};
      v.sum   = r[7:0];
      v.carry = r[8];
      run_vec(v);
      check("sat_count", int'(op_count), (n < 15) ? n : 15);
    end

    // Random traffic with random backpressure; the scoreboard checks every response
    target = n_rsp + 1000;
    cyc = 0;
    while (n_rsp < target && cyc < 20000) begin
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      req_a = $urandom;
      req_b = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    check("random_done", (n_rsp >= target) ? 1 : 0, 1);
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();
    check("random_op_count", int'(op_count), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
